// File: rtl/pr_timer_bridge.sv
// ============================================================================
// Module   : pr_timer_bridge
// Brief    : Processor-bus responder with two countdown timers (TC0/TC1)
//            driving HWInt[3:2]; register reads are zero-latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pr_timer_bridge #(
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] PrAddr,
    input  logic [31:0] PrWD,
    input  logic [3:0]  PrBE,
    input  logic        IOWrite,
    output logic [31:0] PrRD,
    output logic [7:2]  HWInt,
    output logic        dev_hit
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    logic [31:0] w_rd [2];
    logic [1:0]  w_hit;
    logic [1:0]  w_hw;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_tmr
            localparam logic [31:0] C_BASE = (g == 0) ? TC0_BASE : TC1_BASE;

            state_t      r_state, w_state_nxt;
            logic [3:0]  r_ctrl, w_ctrl_nxt;
            logic [31:0] r_preset, w_preset_nxt;
            logic [31:0] r_count, w_count_nxt;
            logic        r_irq, w_irq_nxt;
            logic        r_hwint;
            logic        w_sel;
            logic [1:0]  w_off;
            logic        w_wr_ctrl;
            logic        w_wr_preset;
            logic [31:0] w_rdata;

            assign w_sel       = (PrAddr[31:4] == C_BASE[31:4]);
            assign w_off       = PrAddr[3:2];
            assign w_hit[g]    = w_sel && (w_off != 2'd3);
            assign w_wr_ctrl   = IOWrite && w_sel && (w_off == 2'd0);
            assign w_wr_preset = IOWrite && w_sel && (w_off == 2'd1);

            always_comb begin
                w_state_nxt  = r_state;
                w_ctrl_nxt   = r_ctrl;
                w_preset_nxt = r_preset;
                w_count_nxt  = r_count;
                w_irq_nxt    = r_irq;
                case (r_state)
                    S_IDLE: begin
                        if (r_ctrl[0]) w_state_nxt = S_LOAD;
                    end
                    S_LOAD: begin
                        w_count_nxt = r_preset;
                        w_state_nxt = S_CNT;
                    end
                    S_CNT: begin
                        if (!r_ctrl[0]) begin
                            w_state_nxt = S_IDLE;
                        end else if (r_count > 32'd1) begin
                            w_count_nxt = r_count - 32'd1;
                        end else begin
                            w_count_nxt = 32'd0;
                            w_state_nxt = S_INT;
                            w_irq_nxt   = 1'b1;
                        end
                    end
                    default: begin
                        // Only MODE=01 reloads; 10/11 fall back to one-shot.
                        if (r_ctrl[2:1] == 2'b01) begin
                            w_state_nxt = S_LOAD;
                            w_irq_nxt   = 1'b0;
                        end else begin
                            w_ctrl_nxt[0] = 1'b0;
                            w_state_nxt   = S_IDLE;
                        end
                    end
                endcase
                // CPU writes override the FSM's EN clear and always drop the flag.
                if (w_wr_ctrl) begin
                    if (PrBE[0]) w_ctrl_nxt = PrWD[3:0];
                    w_irq_nxt = 1'b0;
                end
                if (w_wr_preset) begin
                    for (int b = 0; b < 4; b++) begin
                        if (PrBE[b]) w_preset_nxt[8*b +: 8] = PrWD[8*b +: 8];
                    end
                    w_irq_nxt = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state  <= S_IDLE;
                    r_ctrl   <= 4'd0;
                    r_preset <= 32'd0;
                    r_count  <= 32'd0;
                    r_irq    <= 1'b0;
                    r_hwint  <= 1'b0;
                end else begin
                    r_state  <= w_state_nxt;
                    r_ctrl   <= w_ctrl_nxt;
                    r_preset <= w_preset_nxt;
                    r_count  <= w_count_nxt;
                    r_irq    <= w_irq_nxt;
                    r_hwint  <= w_irq_nxt & w_ctrl_nxt[3];
                end
            end

            always_comb begin
                w_rdata = 32'd0;
                if (w_sel) begin
                    case (w_off)
                        2'd0:    w_rdata = {28'd0, r_ctrl};
                        2'd1:    w_rdata = r_preset;
                        2'd2:    w_rdata = r_count;
                        default: w_rdata = 32'd0;
                    endcase
                end
            end

            assign w_rd[g] = w_rdata;
            assign w_hw[g] = r_hwint;
        end
    endgenerate

    assign PrRD    = w_rd[0] | w_rd[1];
    assign dev_hit = |w_hit;
    assign HWInt   = {4'b0000, w_hw};

endmodule

`default_nettype wire
